// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment pattern constants, digit type and monitor state enum
package seg7_pkg;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] seg_t;

    typedef enum logic {
        NO_REF = 1'b0,
        TRACK  = 1'b1
    } mon_state_t;

    // Segment patterns, bit6..bit0 = g f e d c b a, active high.
    localparam seg_t SEG7_0     = 7'h3F;
    localparam seg_t SEG7_1     = 7'h06;
    localparam seg_t SEG7_2     = 7'h5B;
    localparam seg_t SEG7_3     = 7'h4F;
    localparam seg_t SEG7_4     = 7'h66;
    localparam seg_t SEG7_5     = 7'h6D;
    localparam seg_t SEG7_6     = 7'h7D;
    localparam seg_t SEG7_7     = 7'h07;
    localparam seg_t SEG7_8     = 7'h7F;
    localparam seg_t SEG7_9     = 7'h6F;
    localparam seg_t SEG7_BLANK = 7'h00;

endpackage

// File: rtl/seg7_monitor_decode.sv
// rtl/seg7_monitor_decode.sv - combinational 7-segment pattern to BCD digit decoder
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output digit_t     digit,
    output logic       is_valid,
    output logic       is_blank
);

    // Table lookup; anything outside the ten digit patterns is not a digit.
    always_comb begin
        digit    = 4'd0;
        is_valid = 1'b1;
        is_blank = (pattern == SEG7_BLANK);
        case (pattern)
            SEG7_0:  digit = 4'd0;
            SEG7_1:  digit = 4'd1;
            SEG7_2:  digit = 4'd2;
            SEG7_3:  digit = 4'd3;
            SEG7_4:  digit = 4'd4;
            SEG7_5:  digit = 4'd5;
            SEG7_6:  digit = 4'd6;
            SEG7_7:  digit = 4'd7;
            SEG7_8:  digit = 4'd8;
            SEG7_9:  digit = 4'd9;
            default: is_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_monitor.sv
// rtl/seg7_monitor.sv - debounced 7-segment bus receiver with step classification and error count
module seg7_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       step_up,
    output logic       step_down,
    output logic       jump,
    output logic       blank,
    output logic       seg_error,
    output logic [7:0] err_count,
    output logic       has_ref
);

    localparam logic [3:0] STABLE    = 4'(STABLE_CYCLES);
    localparam logic [3:0] STABLE_M1 = 4'(STABLE_CYCLES - 1);

    logic [6:0] s1, s2, p, last_pat;
    logic [3:0] cnt;
    logic       same, accept;
    digit_t     dec_digit;
    logic       dec_valid, dec_blank;
    mon_state_t state, state_d;
    digit_t     digit_d;
    logic       digit_valid_d, step_up_d, step_down_d, jump_d, blank_d, seg_error_d;
    logic [7:0] err_count_d;
    digit_t     up_target, down_target;

    // Two-flop synchronizer for the asynchronous segment bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 7'd0;
            s2 <= 7'd0;
        end else begin
            s1 <= seg_in;
            s2 <= s1;
        end
    end

    assign p = SEG_ACTIVE_LOW ? ~s2 : s2;

    // s1 is the value p will take next cycle, so comparing s1 with s2 tells whether
    // p is about to repeat; inversion does not change equality.
    assign same   = (s1 == s2);
    assign accept = same && (cnt == STABLE_M1) && (p != last_pat);

    // Saturating run-length counter of identical synchronized samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (!same) begin
            cnt <= 4'd0;
        end else if (cnt != STABLE) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Remember the last accepted pattern so a held or returning pattern is not re-reported.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_pat <= 7'd0;
        end else if (accept) begin
            last_pat <= p;
        end
    end

    seg7_decode u_decode (
        .pattern  (p),
        .digit    (dec_digit),
        .is_valid (dec_valid),
        .is_blank (dec_blank)
    );

    assign up_target   = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    assign down_target = (digit == 4'd0) ? 4'd9 : digit - 4'd1;

    // Next state and next registered outputs for an accept event.
    always_comb begin
        state_d       = state;
        digit_d       = digit;
        digit_valid_d = 1'b0;
        step_up_d     = 1'b0;
        step_down_d   = 1'b0;
        jump_d        = 1'b0;
        blank_d       = blank;
        seg_error_d   = 1'b0;
        err_count_d   = err_count;
        if (accept) begin
            if (dec_valid) begin
                digit_d       = dec_digit;
                digit_valid_d = 1'b1;
                blank_d       = 1'b0;
                if (state == TRACK) begin
                    if (dec_digit == up_target) begin
                        step_up_d = 1'b1;
                    end else if (dec_digit == down_target) begin
                        step_down_d = 1'b1;
                    end else begin
                        jump_d = 1'b1;
                    end
                end
                state_d = TRACK;
            end else if (dec_blank) begin
                blank_d = 1'b1;
                state_d = NO_REF;
            end else begin
                seg_error_d = 1'b1;
                blank_d     = 1'b0;
                if (err_count != 8'hFF) begin
                    err_count_d = err_count + 8'd1;
                end
                state_d = NO_REF;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= NO_REF;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            step_up     <= 1'b0;
            step_down   <= 1'b0;
            jump        <= 1'b0;
            blank       <= 1'b0;
            seg_error   <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            state       <= state_d;
            digit       <= digit_d;
            digit_valid <= digit_valid_d;
            step_up     <= step_up_d;
            step_down   <= step_down_d;
            jump        <= jump_d;
            blank       <= blank_d;
            seg_error   <= seg_error_d;
            err_count   <= err_count_d;
        end
    end

    assign has_ref = (state == TRACK);

endmodule

// File: tb/tb_seg7_monitor.sv
// tb/tb_seg7_monitor.sv - scoreboard testbench for seg7_monitor
module tb_seg7_monitor;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst_n, rst_n_b;
    logic [6:0] seg_in, seg_in_b;
    logic [3:0] digit, digit_b;
    logic       digit_valid, step_up, step_down, jump, blank, seg_error, has_ref;
    logic       digit_valid_b, step_up_b, step_down_b, jump_b, blank_b, seg_error_b, has_ref_b;
    logic [7:0] err_count, err_count_b;

    always #5 clk = ~clk;

    seg7_monitor #(.STABLE_CYCLES(SC), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit(digit), .digit_valid(digit_valid),
        .step_up(step_up), .step_down(step_down), .jump(jump), .blank(blank),
        .seg_error(seg_error), .err_count(err_count), .has_ref(has_ref)
    );

    seg7_monitor #(.STABLE_CYCLES(SC), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .seg_in(seg_in_b), .digit(digit_b), .digit_valid(digit_valid_b),
        .step_up(step_up_b), .step_down(step_down_b), .jump(jump_b), .blank(blank_b),
        .seg_error(seg_error_b), .err_count(err_count_b), .has_ref(has_ref_b)
    );

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int edge_no;
        int dig;
        int flags;   // {valid, up, down, jump, error}
        int blk;
        int errc;
        int href;
    } exp_t;

    exp_t q[$];

    logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic [6:0] m_last = 7'd0;
    logic [6:0] cur    = 7'd0;
    int m_digit = 0, m_has_ref = 0, m_blank = 0, m_errc = 0;
    bit mon_en = 1'b0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at edge %0d", name, act, exp, edge_cnt);
        end
    endfunction

    // -1 = blank, -2 = invalid, else digit value
    function automatic int decode_m(input logic [6:0] pat);
        for (int i = 0; i < 10; i++) if (tbl[i] == pat) return i;
        if (pat == 7'h00) return -1;
        return -2;
    endfunction

    function automatic void model_accept(input logic [6:0] pat, input int at_edge);
        exp_t e;
        int d, diff;
        bit up, dn, jp;
        d = decode_m(pat);
        e.edge_no = at_edge;
        e.flags = 0;
        if (d >= 0) begin
            up = 0; dn = 0; jp = 0;
            if (m_has_ref != 0) begin
                diff = (d - m_digit + 10) % 10;
                up = (diff == 1);
                dn = (diff == 9);
                jp = !up && !dn;
            end
            e.flags = {27'd0, 1'b1, up, dn, jp, 1'b0};
            m_digit = d; m_has_ref = 1; m_blank = 0;
        end else if (d == -1) begin
            m_blank = 1; m_has_ref = 0;
        end else begin
            e.flags = 1;
            m_errc = (m_errc < 255) ? m_errc + 1 : 255;
            m_has_ref = 0; m_blank = 0;
        end
        e.dig = m_digit; e.blk = m_blank; e.errc = m_errc; e.href = m_has_ref;
        m_last = pat;
        q.push_back(e);
    endfunction

    // Drive one held pattern; the model decides whether and when it is accepted.
    task automatic seg(input logic [6:0] pat, input int h);
        int e1;
        #1;
        seg_in = pat;
        cur = pat;
        e1 = edge_cnt + 1;
        if (h >= SC + 1 && pat != m_last) model_accept(pat, e1 + SC + 1);
        repeat (h) @(posedge clk);
    endtask

    // Monitor: any output event pops one expectation and compares every field.
    logic blank_prev = 1'b0;
    exp_t me;
    always @(negedge clk) begin
        if (mon_en) begin
            if (digit_valid || seg_error || step_up || step_down || jump || (blank && !blank_prev)) begin
                check("pending_expect", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    me = q.pop_front();
                    check("accept_edge", edge_cnt, me.edge_no);
                    check("pulses", int'({digit_valid, step_up, step_down, jump, seg_error}), me.flags);
                    check("digit", int'(digit), me.dig);
                    check("blank", int'(blank), me.blk);
                    check("err_count", int'(err_count), me.errc);
                    check("has_ref", int'(has_ref), me.href);
                end
            end
        end
        blank_prev <= blank;
    end

    initial begin
        logic [6:0] pat;
        int r, h, d, found;

        rst_n = 1'b0; rst_n_b = 1'b0; seg_in = 7'd0; seg_in_b = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({digit, digit_valid, step_up, step_down, jump, blank, seg_error, err_count, has_ref}), 0);
        check("reset_outputs_b", int'({digit_b, digit_valid_b, step_up_b, step_down_b, jump_b, blank_b, seg_error_b, err_count_b, has_ref_b}), 0);

        // Active-low instance: reset mid-count, then re-accept of 0x79 (digit 1).
        rst_n = 1'b1; rst_n_b = 1'b1; seg_in_b = 7'h79;
        repeat (3) @(posedge clk);
        #1 rst_n_b = 1'b0;
        @(posedge clk);
        #1 rst_n_b = 1'b1;
        check("midreset_outputs_b", int'({digit_b, digit_valid_b, step_up_b, step_down_b, jump_b, blank_b, seg_error_b, err_count_b, has_ref_b}), 0);
        found = 0;
        for (int k = 1; k <= 20 && found == 0; k++) begin
            @(posedge clk);
            #1;
            if (digit_valid_b) found = k;
        end
        check("lowact_latency", found, 6);
        check("lowact_digit", int'(digit_b), 1);
        check("lowact_has_ref", int'(has_ref_b), 1);

        // Main instance: directed sequences through the scoreboard.
        @(posedge clk);
        mon_en = 1'b1;
        seg(7'h06, 10);
        for (int i = 0; i < 10; i++) seg(tbl[i], 8);
        seg(7'h3F, 8);
        seg(7'h5B, 8); seg(7'h4F, 2); seg(7'h5B, 8);
        seg(7'h4F, 8); seg(7'h66, 8); seg(7'h7F, 8); seg(7'h3F, 8); seg(7'h6F, 8);
        seg(7'h06, SC); seg(7'h6F, 8);
        for (int i = 0; i < 300; i++) begin
            seg(7'h55, SC + 1);
            seg(tbl[i % 10], SC + 1);
        end
        seg(7'h00, 8);
        check("err_saturated", int'(err_count), 255);

        // Randomized segments: mostly neighbouring digits, some blanks, random codes and glitches.
        for (int i = 0; i < 400; i++) begin
            do begin
                r = $urandom_range(0, 99);
                if (r < 55) begin
                    case ($urandom_range(0, 2))
                        0: d = (m_digit + 1) % 10;
                        1: d = (m_digit + 9) % 10;
                        default: d = $urandom_range(0, 9);
                    endcase
                    pat = tbl[d];
                end else if (r < 65) begin
                    pat = 7'h00;
                end else begin
                    pat = 7'($urandom_range(0, 127));
                end
            end while (pat == cur);
            h = ($urandom_range(0, 99) < 70) ? $urandom_range(SC + 1, SC + 6) : $urandom_range(1, SC);
            seg(pat, h);
        end
        seg((cur == 7'h06) ? 7'h5B : 7'h06, 20);

        found = 0;
        for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
        check("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
